// File: rtl/song_autoplayer.sv
// Plays the first phrase of Ode to Joy as note codes, one note per ROM entry, with a
// `none` gap after each note.  States: IDLE = silent | SOUND = note audible | GAP = inter-note silence.
module song_autoplayer #(
    parameter int         HALF_BEAT_TICKS = 200,
    parameter int         GAP_TICKS       = 40,
    parameter bit         LOOP            = 1'b0,
    parameter logic [3:0] NOTE_NONE       = 4'd0,
    parameter logic [3:0] NOTE_C4         = 4'd1,
    parameter logic [3:0] NOTE_D          = 4'd2,
    parameter logic [3:0] NOTE_E          = 4'd3,
    parameter logic [3:0] NOTE_F          = 4'd4,
    parameter logic [3:0] NOTE_G          = 4'd5
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       TICK,
    input  logic       START,
    input  logic       STOP,
    output logic [3:0] note,
    output logic       playing,
    output logic [3:0] index,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOUND = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0]  LAST_IDX = 4'd14;
    localparam logic [15:0] GAP_LAST = 16'(GAP_TICKS - 1);

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  note_q, note_d;
    logic        playing_q, playing_d;
    logic        done_q, done_d;

    logic [6:0]  rom_cur;
    logic [6:0]  rom_nxt;
    logic [15:0] sound_last;

    // Song ROM entry: {note code, duration in half-beats}
    function automatic logic [6:0] song_rom(input logic [3:0] i);
        case (i)
            4'd0:    song_rom = {NOTE_E,  3'd2};
            4'd1:    song_rom = {NOTE_E,  3'd2};
            4'd2:    song_rom = {NOTE_F,  3'd2};
            4'd3:    song_rom = {NOTE_G,  3'd2};
            4'd4:    song_rom = {NOTE_G,  3'd2};
            4'd5:    song_rom = {NOTE_F,  3'd2};
            4'd6:    song_rom = {NOTE_E,  3'd2};
            4'd7:    song_rom = {NOTE_D,  3'd2};
            4'd8:    song_rom = {NOTE_C4, 3'd2};
            4'd9:    song_rom = {NOTE_C4, 3'd2};
            4'd10:   song_rom = {NOTE_D,  3'd2};
            4'd11:   song_rom = {NOTE_E,  3'd2};
            4'd12:   song_rom = {NOTE_E,  3'd3};
            4'd13:   song_rom = {NOTE_D,  3'd1};
            4'd14:   song_rom = {NOTE_D,  3'd4};
            default: song_rom = {NOTE_NONE, 3'd0};
        endcase
    endfunction

    assign rom_cur    = song_rom(idx_q);
    assign sound_last = 16'(int'(rom_cur[2:0]) * HALF_BEAT_TICKS - GAP_TICKS - 1);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = TICK ? cnt_q + 16'd1 : cnt_q;
        done_d  = 1'b0;

        if (STOP) begin
            state_d = IDLE;
            idx_d   = 4'd0;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = 16'd0;
                    if (START) begin
                        state_d = SOUND;
                        idx_d   = 4'd0;
                    end
                end
                SOUND: begin
                    if (TICK && cnt_q == sound_last) begin
                        state_d = GAP;
                        cnt_d   = 16'd0;
                    end
                end
                GAP: begin
                    if (TICK && cnt_q == GAP_LAST) begin
                        cnt_d = 16'd0;
                        if (idx_q < LAST_IDX) begin
                            state_d = SOUND;
                            idx_d   = idx_q + 4'd1;
                        end else begin
                            done_d  = 1'b1;
                            idx_d   = 4'd0;
                            state_d = LOOP ? SOUND : IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    idx_d   = 4'd0;
                    cnt_d   = 16'd0;
                end
            endcase
        end
    end

    // Outputs are derived from the next state so they register in step with it.
    assign rom_nxt   = song_rom(idx_d);
    assign note_d    = (state_d == SOUND) ? rom_nxt[6:3] : NOTE_NONE;
    assign playing_d = (state_d != IDLE);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q   <= IDLE;
            idx_q     <= 4'd0;
            cnt_q     <= 16'd0;
            note_q    <= NOTE_NONE;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            note_q    <= note_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign note    = note_q;
    assign playing = playing_q;
    assign index   = idx_q;
    assign done    = done_q;

endmodule
